mod_bus_arbiter: RTL and testbench
==================================

Name: mod_bus_arbiter

Overview:
- Round-robin arbiter that shares one mod_if bus, on its master modport side, among N_REQ requesting masters.
- Grants exactly one owner at a time, limits each tenure to MAX_HOLD cycles, and inserts a one-cycle turnaround between owners.
- Sits beside the mod_if instance in the testbench/top level; its one-hot grant drives the mux that selects which master's signals reach the bus.

Parameters:
- N_REQ, 4, number of requesting masters; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; legal range 1..255.
- ID_W, $clog2(N_REQ), width of the owner index. Derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  request per master; level-sensitive, held high while bus is wanted.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- owner  output  ID_W  index of current owner; valid only while busy=1.
- busy  output  1  high exactly when gnt is non-zero.
- hold_expired  output  1  one-cycle pulse when a tenure is cut at MAX_HOLD.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; gnt=0, owner=0, busy=0, hold_expired=0.
  - hold_cnt=0; last_owner=N_REQ-1, so master 0 has first priority.
  - Reset asserted mid-tenure drops gnt immediately, without waiting for a clock edge.
- States: IDLE, OWN, TURN.
- Arbitration, combinational in IDLE and TURN:
  - Search req starting at index last_owner+1, wrapping modulo N_REQ.
  - The first set bit wins. Result is sampled at the clock edge.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: next cycle enter OWN with gnt=onehot(winner), owner=winner, last_owner=winner, hold_cnt=1.
  - Latency is one cycle from req observed high to gnt high.
- OWN, release on req drop:
  - req[owner]==0 at an edge: gnt=0 next cycle; go to TURN; hold_expired stays 0.
- OWN, release on timeout:
  - hold_cnt==MAX_HOLD with req[owner] still 1: gnt=0 next cycle; go to TURN; hold_expired=1 for that one cycle.
- OWN, continue:
  - Otherwise: hold_cnt increments, gnt is unchanged.
  - Grant is never longer than MAX_HOLD cycles.
- TURN, exactly one cycle with gnt=0 (bus turnaround):
  - Arbitrates like IDLE.
  - Any req: go to OWN next cycle.
  - No req: go to IDLE.
- Fairness:
  - Because the search starts after last_owner, a timed-out master still requesting goes to the back of the line.
  - If it is the only requester, it is re-granted after the one TURN cycle.
- Ignored requests: req changes on non-owner bits during OWN have no effect until the next arbitration.
- Invariants on every cycle:
  - gnt is zero or one-hot.
  - busy == |gnt.
  - Minimum gap between two different grants is exactly 1 cycle.
- MAX_HOLD=1 is legal: every tenure lasts 1 cycle, followed by TURN, with hold_expired pulsing each time req is held.
- hold_cnt width: $clog2(MAX_HOLD+1); it must not wrap.

Test Plan:
- Reset, single request:
  - Stimulus: release rst_n, then req=4'b0100 held for 3 cycles, then 0.
  - Required: gnt=4'b0100 one cycle after req rises, owner=2, busy=1 for 3 cycles.
  - Required after release: gnt=0, one TURN cycle, then IDLE; hold_expired never pulses.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held, each master dropping its req 2 cycles after its grant.
  - Required: grant order 0,1,2,3,0 with exactly one gnt=0 cycle between tenures.
- Timeout:
  - Stimulus: MAX_HOLD=8, req=4'b0001 held for 20 cycles.
  - Required: gnt=4'b0001 for 8 cycles, hold_expired=1 on the following cycle with gnt=0, then re-grant to master 0.
- Timeout fairness:
  - Stimulus: req=4'b0011 held continuously.
  - Required: grant alternates 0,1,0,1, each tenure exactly 8 cycles.
- Reset mid-operation:
  - Stimulus: rst_n low at cycle 3 of master 1's tenure, asynchronously, between clock edges.
  - Required: gnt=0 and busy=0 before the next edge.
  - Required after rst_n release with req=4'b0010: master 1 is granted again, since last_owner was reset to 3.
- Late non-owner request:
  - Stimulus: master 3 owns; req[0] rises mid-tenure; req[3] drops.
  - Required: TURN for one cycle, then gnt=4'b0001. gnt is never two-hot, checked every cycle by assertion.

Source files
------------

// File: rtl/mod_bus_arbiter.sv
// Round-robin bus arbiter: one owner at a time, tenure capped at MAX_HOLD
// cycles, and a single idle turnaround cycle between consecutive owners.
//
// Handshake: req[i] is a level request held high while master i wants the
// bus; gnt[i] is a registered one-hot grant that stays high for as long as
// master i owns the bus. The master owns the bus in every cycle gnt[i]=1 and
// must keep req[i] high to keep ownership. Dropping req[i] or reaching
// MAX_HOLD cycles ends the tenure at the next edge.
module mod_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  owner,
  output logic             busy,
  output logic             hold_expired,
  output logic [1:0]       state_o
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_CNT = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   owner_q;
  logic [ID_W-1:0]   last_q;
  logic [HW-1:0]     hold_cnt_q;
  logic              hold_exp_q;

  logic              found_d;
  logic [ID_W-1:0]   winner_d;
  int                arb_idx;

  // Round-robin search: first requester strictly after the last owner, wrapping.
  always_comb begin
    found_d  = 1'b0;
    winner_d = '0;
    arb_idx  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_idx = (int'(last_q) + i) % N_REQ;
      if (!found_d && req[arb_idx]) begin
        found_d  = 1'b1;
        winner_d = ID_W'(arb_idx);
      end
    end
  end

  // Arbitration FSM with all outputs registered; reset clears the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      hold_exp_q <= 1'b0;
    end else begin
      hold_exp_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_TURN: begin
          if (found_d) begin
            state_q    <= ST_OWN;
            gnt_q      <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_d;
            owner_q    <= winner_d;
            last_q     <= winner_d;
            hold_cnt_q <= HW'(1);
          end else begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
          end
        end
        ST_OWN: begin
          if (!req[owner_q]) begin
            state_q    <= ST_TURN;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == MAX_CNT) begin
            state_q    <= ST_TURN;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            hold_exp_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          gnt_q      <= '0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign busy         = |gnt_q;
  assign hold_expired = hold_exp_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mod_bus_arbiter.sv
// Directed bench for mod_bus_arbiter: main instance (N_REQ=4, MAX_HOLD=8)
// plus a MAX_HOLD=1 instance for the single-cycle-tenure corner.
module tb_mod_bus_arbiter;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_OWN  = 32'd1;
  localparam logic [31:0] S_TURN = 32'd2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic [1:0] owner, owner1;
  logic       busy, busy1;
  logic       hexp, hexp1;
  logic [1:0] st, st1;

  int n_checks = 0;
  int n_errors = 0;

  mod_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .owner(owner),
    .busy(busy), .hold_expired(hexp), .state_o(st)
  );

  mod_bus_arbiter #(.N_REQ(4), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .owner(owner1),
    .busy(busy1), .hold_expired(hexp1), .state_o(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    req1  = '0;
    #1;
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_hexp",  32'(hexp),  32'h0);
    chk("rst_state", 32'(st),    S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // every-cycle invariants: one-hot grant, busy tracks grant, no back-to-back owners
  logic [3:0] prev_gnt = '0, prev_gnt1 = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot",  32'($onehot0(gnt)), 32'h1);
      chk("busy_eq", 32'(busy), 32'(|gnt));
      chk("gap",     32'(prev_gnt != 0 && gnt != 0 && gnt != prev_gnt), 32'h0);
      chk("onehot1", 32'($onehot0(gnt1)), 32'h1);
      chk("gap1",    32'(prev_gnt1 != 0 && gnt1 != 0 && gnt1 != prev_gnt1), 32'h0);
    end
    prev_gnt  = gnt;
    prev_gnt1 = gnt1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] order [5];

  initial begin
    rst_n = 1'b1;
    req   = '0;
    req1  = '0;
    #1;

    // single request: 3-cycle tenure, TURN, IDLE
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_gnt",   32'(gnt),   32'h4);
      chk("single_owner", 32'(owner), 32'h2);
      chk("single_busy",  32'(busy),  32'h1);
      chk("single_hexp",  32'(hexp),  32'h0);
    end
    req = '0;
    step();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_turn",    32'(st),  S_TURN);
    chk("single_rel_hexp", 32'(hexp), 32'h0);
    step();
    chk("single_idle", 32'(st),  S_IDLE);
    chk("single_idle_gnt", 32'(gnt), 32'h0);

    // round-robin rotation 0,1,2,3,0 with 2-cycle tenures
    do_reset();
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt1",  32'(gnt),   32'(4'b0001 << order[k]));
      chk("rr_owner", 32'(owner), 32'(order[k]));
      step();
      chk("rr_gnt2",  32'(gnt),   32'(4'b0001 << order[k]));
      req = 4'b1111 & ~(4'b0001 << order[k]);
      step();
      chk("rr_turn_gnt", 32'(gnt), 32'h0);
      chk("rr_turn_st",  32'(st),  S_TURN);
      req = 4'b1111;
    end
    req = '0;
    step();
    step();
    chk("rr_idle", 32'(st), S_IDLE);

    // timeout on a lone requester, then re-grant
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_gnt",  32'(gnt),  32'h1);
      chk("to_hexp", 32'(hexp), 32'h0);
    end
    step();
    chk("to_cut_gnt",  32'(gnt),  32'h0);
    chk("to_cut_hexp", 32'(hexp), 32'h1);
    chk("to_cut_st",   32'(st),   S_TURN);
    step();
    chk("to_regnt",      32'(gnt),  32'h1);
    chk("to_regnt_hexp", 32'(hexp), 32'h0);
    for (int i = 0; i < 3; i++) step();
    req = '0;
    step();
    chk("to_rel_hexp", 32'(hexp), 32'h0);
    step();

    // timeout fairness: two persistent requesters alternate in 8-cycle tenures
    do_reset();
    req = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        chk("fair_gnt", 32'(gnt), 32'(4'b0001 << (t % 2)));
      end
      step();
      chk("fair_cut_gnt",  32'(gnt),  32'h0);
      chk("fair_cut_hexp", 32'(hexp), 32'h1);
    end
    req = '0;
    step();
    step();

    // asynchronous reset in the middle of master 1's tenure
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_gnt", 32'(gnt), 32'h2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",  32'(gnt),  32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_st",   32'(st),   S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_regnt",       32'(gnt),   32'h2);
    chk("mid_regnt_owner", 32'(owner), 32'h1);
    req = '0;
    step();
    step();

    // late non-owner request while master 3 owns
    do_reset();
    req = 4'b1000;
    step();
    chk("late_gnt3", 32'(gnt), 32'h8);
    step();
    req = 4'b1001;
    step();
    chk("late_hold3", 32'(gnt), 32'h8);
    chk("late_own_st", 32'(st), S_OWN);
    req = 4'b0001;
    step();
    chk("late_turn_gnt", 32'(gnt), 32'h0);
    chk("late_turn_st",  32'(st),  S_TURN);
    step();
    chk("late_gnt0",   32'(gnt),   32'h1);
    chk("late_owner0", 32'(owner), 32'h0);
    req = '0;
    step();
    step();

    // MAX_HOLD=1: every tenure is one cycle followed by a timeout TURN
    do_reset();
    req1 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mh1_gnt",  32'(gnt1),  32'h2);
      chk("mh1_hexp", 32'(hexp1), 32'h0);
      step();
      chk("mh1_cut_gnt",  32'(gnt1),  32'h0);
      chk("mh1_cut_hexp", 32'(hexp1), 32'h1);
      chk("mh1_cut_st",   32'(st1),   S_TURN);
    end
    req1 = '0;
    step();
    chk("mh1_idle", 32'(st1), S_IDLE);
    chk("mh1_idle_gnt", 32'(gnt1), 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
